bitstream_accum: RTL and testbench

Parametrised multi-channel bitstream accumulator. Counts ones on NCH 1-bit input streams over a fixed window of WIN enabled samples. At each window end it publishes per-channel counts and a scaled channel sum, in unipolar or bipolar encoding, through a valid/ready output port with overrun detection. It sits between the stochastic/pulse-stream front end and the downstream word-level datapath, and generalises the earlier fixed 4-channel, 32-sample, ×2 adder.

---
 rtl/bitstream_pkg.sv | 31 +++
 rtl/bitstream_accum_if.sv | 32 +++
 rtl/bs_chan_counter.sv | 30 +++
 rtl/bitstream_accum.sv | 111 +++++++++++
 tb/tb_bitstream_accum.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/bitstream_pkg.sv
// Shared definitions for the multi-channel bitstream accumulator:
// width helpers and the sum-encoding mode constants.
package bitstream_pkg;

  localparam logic MODE_UNIPOLAR = 1'b0;
  localparam logic MODE_BIPOLAR  = 1'b1;

  // Ceiling log2; clog2(1) = 0.
  function automatic int clog2(input int n);
    int r;
    int v;
    r = 0;
    v = n - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

  // Width of a per-channel count that must hold 0..WIN.
  function automatic int cw_width(input int win);
    return clog2(win + 1);
  endfunction

  // Width of the signed scaled sum: magnitude bits, shift, sign.
  function automatic int ow_width(input int nch, input int win, input int shift);
    return clog2(nch * win + 1) + shift + 1;
  endfunction

endpackage

// File: rtl/bitstream_accum_if.sv
// Result port of the bitstream accumulator.
// Handshake: the producer raises out_valid with out_sum/out_ch stable; a
// transfer happens on any clock edge where out_valid && out_ready. The
// producer never waits for out_ready: a new result overwrites an unaccepted
// one and raises the sticky overrun flag.
interface bitstream_accum_if #(
  parameter int NCH   = 4,
  parameter int WIN   = 32,
  parameter int SHIFT = 1
);
  import bitstream_pkg::*;

  localparam int CW = cw_width(WIN);
  localparam int OW = ow_width(NCH, WIN, SHIFT);

  logic [OW-1:0]     out_sum;
  logic [NCH*CW-1:0] out_ch;
  logic              out_valid;
  logic              out_ready;
  logic              overrun;

  modport master (
    output out_sum, out_ch, out_valid, overrun,
    input  out_ready
  );

  modport slave (
    input  out_sum, out_ch, out_valid, overrun,
    output out_ready
  );

endinterface

// File: rtl/bs_chan_counter.sv
// One channel's ones counter: loads the bit at window start, adds otherwise.
module bs_chan_counter #(
  parameter int CW = 6
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          first,
  input  logic          clr,
  input  logic          bit_i,
  output logic [CW-1:0] acc_o
);

  logic [CW-1:0] acc_q;

  // Accumulate enabled samples; clr wins over en, first restarts the count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_q <= '0;
    end else if (clr) begin
      acc_q <= '0;
    end else if (en) begin
      if (first) acc_q <= CW'(bit_i);
      else       acc_q <= acc_q + CW'(bit_i);
    end
  end

  assign acc_o = acc_q;

endmodule

// File: rtl/bitstream_accum.sv
// Multi-channel bitstream accumulator: counts ones per channel over a window
// of WIN enabled samples and publishes counts plus a scaled channel sum.
module bitstream_accum
  import bitstream_pkg::*;
#(
  parameter int NCH   = 4,
  parameter int WIN   = 32,
  parameter int SHIFT = 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           en_in,
  input  logic           clr,
  input  logic [NCH-1:0] bits_in,
  input  logic           bipolar,
  bitstream_accum_if.master out_if
);

  localparam int CW = cw_width(WIN);
  localparam int OW = ow_width(NCH, WIN, SHIFT);
  localparam int SW = clog2(NCH * WIN + 1);
  localparam int PW = clog2(WIN);

  localparam logic [PW-1:0] LAST  = PW'(WIN - 1);
  localparam logic [OW-1:0] TOTAL = OW'(NCH * WIN);

  logic [PW-1:0]     phase_q, phase_d;
  logic              first;
  logic              complete;
  logic [NCH*CW-1:0] acc;
  logic [NCH*CW-1:0] next_ch;
  logic [SW-1:0]     sum;
  logic [OW-1:0]     sum_ext;
  logic [OW-1:0]     conv;

  logic [OW-1:0]     out_sum_q;
  logic [NCH*CW-1:0] out_ch_q;
  logic              valid_q;
  logic              overrun_q;

  assign first    = (phase_q == '0);
  // A window completes on the WIN-th enabled sample; clr discards that sample.
  assign complete = en_in && (phase_q == LAST) && !clr;

  for (genvar g = 0; g < NCH; g++) begin : g_chan
    bs_chan_counter #(.CW(CW)) u_chan (
      .clk   (clk),
      .rst   (rst),
      .en    (en_in),
      .first (first),
      .clr   (clr),
      .bit_i (bits_in[g]),
      .acc_o (acc[g*CW +: CW])
    );
  end

  // Phase advance with wrap at the window end; holds while disabled.
  always_comb begin
    phase_d = phase_q;
    if (en_in) begin
      if (phase_q == LAST) phase_d = '0;
      else                 phase_d = phase_q + PW'(1);
    end
  end

  // Final counts include the current sample; sum them and encode the result.
  always_comb begin
    next_ch = '0;
    sum     = '0;
    for (int i = 0; i < NCH; i++) begin
      next_ch[i*CW +: CW] = acc[i*CW +: CW] + CW'(bits_in[i]);
      sum = sum + SW'(next_ch[i*CW +: CW]);
    end
    sum_ext = OW'(sum);
    if (bipolar == MODE_BIPOLAR) conv = ((sum_ext << 1) - TOTAL) << SHIFT;
    else                         conv = sum_ext << SHIFT;
  end

  // Phase, output registers, valid/ready handshake and sticky overrun.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      phase_q   <= '0;
      out_sum_q <= '0;
      out_ch_q  <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else if (clr) begin
      phase_q   <= '0;
      out_sum_q <= '0;
      out_ch_q  <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      phase_q <= phase_d;
      if (complete) begin
        out_sum_q <= conv;
        out_ch_q  <= next_ch;
        valid_q   <= 1'b1;
        if (valid_q && !out_if.out_ready) overrun_q <= 1'b1;
      end else if (valid_q && out_if.out_ready) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign out_if.out_sum   = out_sum_q;
  assign out_if.out_ch    = out_ch_q;
  assign out_if.out_valid = valid_q;
  assign out_if.overrun   = overrun_q;

endmodule

// File: tb/tb_bitstream_accum.sv
// Directed bench for bitstream_accum at default parameters (4 ch, 32 samples, x2).
module tb_bitstream_accum;

  localparam int NCH   = 4;
  localparam int WIN   = 32;
  localparam int SHIFT = 1;
  localparam int CW    = 6;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           en_in = 1'b0;
  logic           clr = 1'b0;
  logic           bipolar = 1'b0;
  logic [NCH-1:0] bits_in = '0;

  int checks = 0;
  int errors = 0;

  bitstream_accum_if #(.NCH(NCH), .WIN(WIN), .SHIFT(SHIFT)) bus ();

  bitstream_accum #(.NCH(NCH), .WIN(WIN), .SHIFT(SHIFT)) dut (
    .clk     (clk),
    .rst     (rst),
    .en_in   (en_in),
    .clr     (clr),
    .bits_in (bits_in),
    .bipolar (bipolar),
    .out_if  (bus)
  );

  // Clock / reset
  always #5 clk = ~clk;

  // Driver tasks: inputs change 1 time unit after the rising edge, outputs sampled there too.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input logic [NCH-1:0] b, input logic bip, input int n);
    en_in   = 1'b1;
    bits_in = b;
    bipolar = bip;
    repeat (n) step();
  endtask

  task automatic do_clr();
    clr = 1'b1;
    step();
    clr = 1'b0;
  endtask

  task automatic test_reset();
    bus.out_ready = 1'b0;
    rst = 1'b0;
    #12;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b expected 0", bus.out_valid); end
    checks++; if (bus.out_sum !== '0) begin errors++; $display("FAIL reset_sum: got %0d expected 0", $signed(bus.out_sum)); end
    checks++; if (bus.out_ch !== '0) begin errors++; $display("FAIL reset_ch: got %h expected 0", bus.out_ch); end
    checks++; if (bus.overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %0b expected 0", bus.overrun); end
    #1 rst = 1'b1;
    step();
  endtask

  task automatic test_unipolar_ones();
    do_clr();
    bus.out_ready = 1'b1;
    run(4'b1111, 1'b0, 31);
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL uni_early_valid: got %0b expected 0", bus.out_valid); end
    step();
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL uni_valid: got %0b expected 1", bus.out_valid); end
    checks++; if ($signed(bus.out_sum) !== 256) begin errors++; $display("FAIL uni_sum: got %0d expected 256", $signed(bus.out_sum)); end
    for (int c = 0; c < NCH; c++) begin
      checks++; if (bus.out_ch[c*CW +: CW] !== 6'd32) begin errors++; $display("FAIL uni_ch%0d: got %0d expected 32", c, bus.out_ch[c*CW +: CW]); end
    end
    en_in = 1'b0;
    step();
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL uni_pulse_end: got %0b expected 0", bus.out_valid); end
    checks++; if ($signed(bus.out_sum) !== 256) begin errors++; $display("FAIL uni_sum_hold: got %0d expected 256", $signed(bus.out_sum)); end
  endtask

  task automatic test_bipolar();
    do_clr();
    bus.out_ready = 1'b1;
    run(4'b0000, 1'b1, 32);
    checks++; if ($signed(bus.out_sum) !== -256) begin errors++; $display("FAIL bip_zeros: got %0d expected -256", $signed(bus.out_sum)); end
    run(4'b1111, 1'b1, 32);
    checks++; if ($signed(bus.out_sum) !== 256) begin errors++; $display("FAIL bip_ones: got %0d expected 256", $signed(bus.out_sum)); end
    // mode is only looked at on the completion edge
    run(4'b0001, 1'b0, 31);
    bipolar = 1'b1;
    step();
    checks++; if ($signed(bus.out_sum) !== -128) begin errors++; $display("FAIL bip_ch0: got %0d expected -128", $signed(bus.out_sum)); end
    checks++; if (bus.out_ch[0 +: CW] !== 6'd32) begin errors++; $display("FAIL bip_ch0_count: got %0d expected 32", bus.out_ch[0 +: CW]); end
    checks++; if (bus.out_ch[CW +: CW] !== 6'd0) begin errors++; $display("FAIL bip_ch1_count: got %0d expected 0", bus.out_ch[CW +: CW]); end
    en_in = 1'b0;
    bipolar = 1'b0;
  endtask

  task automatic test_en_toggle();
    do_clr();
    bus.out_ready = 1'b1;
    bits_in = 4'b1111;
    bipolar = 1'b0;
    for (int i = 0; i < 64; i++) begin
      en_in = (i % 2 == 1);
      step();
      if (i == 62) begin
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL tog_early_valid: got %0b expected 0", bus.out_valid); end
      end
    end
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL tog_valid: got %0b expected 1", bus.out_valid); end
    checks++; if ($signed(bus.out_sum) !== 256) begin errors++; $display("FAIL tog_sum: got %0d expected 256", $signed(bus.out_sum)); end
    checks++; if (bus.out_ch[3*CW +: CW] !== 6'd32) begin errors++; $display("FAIL tog_ch3: got %0d expected 32", bus.out_ch[3*CW +: CW]); end
    en_in = 1'b0;
  endtask

  task automatic test_overrun();
    do_clr();
    bus.out_ready = 1'b0;
    run(4'b0001, 1'b0, 32);
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL ovr_valid1: got %0b expected 1", bus.out_valid); end
    checks++; if (bus.overrun !== 1'b0) begin errors++; $display("FAIL ovr_first: got %0b expected 0", bus.overrun); end
    run(4'b0010, 1'b0, 32);
    checks++; if (bus.out_ch[0 +: CW] !== 6'd0) begin errors++; $display("FAIL ovr_ch0: got %0d expected 0", bus.out_ch[0 +: CW]); end
    checks++; if (bus.out_ch[CW +: CW] !== 6'd32) begin errors++; $display("FAIL ovr_ch1: got %0d expected 32", bus.out_ch[CW +: CW]); end
    checks++; if (bus.overrun !== 1'b1) begin errors++; $display("FAIL ovr_set: got %0b expected 1", bus.overrun); end
    checks++; if ($signed(bus.out_sum) !== 64) begin errors++; $display("FAIL ovr_sum: got %0d expected 64", $signed(bus.out_sum)); end
    en_in = 1'b0;
    step();
    checks++; if (bus.overrun !== 1'b1 || bus.out_valid !== 1'b1) begin errors++; $display("FAIL ovr_sticky: got ovr=%0b valid=%0b expected 1/1", bus.overrun, bus.out_valid); end
    do_clr();
    checks++; if (bus.overrun !== 1'b0) begin errors++; $display("FAIL ovr_clr: got %0b expected 0", bus.overrun); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL ovr_clr_valid: got %0b expected 0", bus.out_valid); end
    checks++; if (bus.out_ch !== '0 || bus.out_sum !== '0) begin errors++; $display("FAIL ovr_clr_data: got ch=%h sum=%0d expected 0/0", bus.out_ch, $signed(bus.out_sum)); end
  endtask

  task automatic test_back_to_back();
    do_clr();
    bus.out_ready = 1'b0;
    run(4'b1111, 1'b0, 32);
    run(4'b0011, 1'b0, 31);
    bus.out_ready = 1'b1;
    step();
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid: got %0b expected 1", bus.out_valid); end
    checks++; if (bus.overrun !== 1'b0) begin errors++; $display("FAIL b2b_overrun: got %0b expected 0", bus.overrun); end
    checks++; if ($signed(bus.out_sum) !== 128) begin errors++; $display("FAIL b2b_sum: got %0d expected 128", $signed(bus.out_sum)); end
    checks++; if (bus.out_ch[2*CW +: CW] !== 6'd0) begin errors++; $display("FAIL b2b_ch2: got %0d expected 0", bus.out_ch[2*CW +: CW]); end
    en_in = 1'b0;
    step();
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL b2b_drop: got %0b expected 0", bus.out_valid); end
  endtask

  task automatic test_clr_mid();
    do_clr();
    bus.out_ready = 1'b1;
    run(4'b1111, 1'b0, 17);
    clr = 1'b1;
    step();
    clr = 1'b0;
    checks++; if (bus.out_valid !== 1'b0 || bus.out_sum !== '0) begin errors++; $display("FAIL clr_mid_out: got valid=%0b sum=%0d expected 0/0", bus.out_valid, $signed(bus.out_sum)); end
    run(4'b0101, 1'b0, 31);
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL clr_mid_early: got %0b expected 0", bus.out_valid); end
    step();
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL clr_mid_valid: got %0b expected 1", bus.out_valid); end
    checks++; if (bus.out_ch !== {6'd0, 6'd32, 6'd0, 6'd32}) begin errors++; $display("FAIL clr_mid_ch: got %h expected %h", bus.out_ch, {6'd0, 6'd32, 6'd0, 6'd32}); end
    checks++; if ($signed(bus.out_sum) !== 128) begin errors++; $display("FAIL clr_mid_sum: got %0d expected 128", $signed(bus.out_sum)); end
    en_in = 1'b0;
  endtask

  task automatic test_rst_mid();
    do_clr();
    bus.out_ready = 1'b0;
    run(4'b1111, 1'b0, 32);
    run(4'b1111, 1'b0, 10);
    #1 rst = 1'b0;
    #1;
    checks++; if (bus.out_valid !== 1'b0 || bus.overrun !== 1'b0) begin errors++; $display("FAIL rst_mid_flags: got valid=%0b ovr=%0b expected 0/0", bus.out_valid, bus.overrun); end
    checks++; if (bus.out_sum !== '0 || bus.out_ch !== '0) begin errors++; $display("FAIL rst_mid_data: got sum=%0d ch=%h expected 0/0", $signed(bus.out_sum), bus.out_ch); end
    #1 rst = 1'b1;
    bus.out_ready = 1'b1;
    run(4'b1000, 1'b1, 31);
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_early: got %0b expected 0", bus.out_valid); end
    step();
    checks++; if (bus.out_ch !== {6'd32, 6'd0, 6'd0, 6'd0}) begin errors++; $display("FAIL rst_mid_ch: got %h expected %h", bus.out_ch, {6'd32, 6'd0, 6'd0, 6'd0}); end
    checks++; if ($signed(bus.out_sum) !== -128) begin errors++; $display("FAIL rst_mid_sum: got %0d expected -128", $signed(bus.out_sum)); end
    en_in = 1'b0;
  endtask

  // Sequence and final report
  initial begin
    test_reset();
    test_unipolar_ones();
    test_bipolar();
    test_en_toggle();
    test_overrun();
    test_back_to_back();
    test_clr_mid();
    test_rst_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
